// File: rtl/alu_seq_if.sv
// Bundle of request, ALU-side and response signals for alu_sequencer.
// Both handshakes use valid/ready: a transfer happens on a rising edge where
// valid and ready are both 1. A producer holds its payload while valid=1 and
// ready=0.
interface alu_seq_if #(parameter int W = 64);
  logic         req_valid;
  logic         req_ready;
  logic [10:0]  req_opcode;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic [W-1:0] alu_num1;
  logic [W-1:0] alu_num2;
  logic [3:0]   alu_op;
  logic [W-1:0] alu_out;
  logic         alu_z;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic         rsp_zero;
  logic         rsp_err;
  logic [15:0]  ops_done;

  // Sequencer side.
  modport slave (
    input  req_valid, req_opcode, req_a, req_b, alu_out, alu_z, rsp_ready,
    output req_ready, alu_num1, alu_num2, alu_op,
           rsp_valid, rsp_result, rsp_zero, rsp_err, ops_done
  );

  // Requester / ALU / consumer side.
  modport master (
    output req_valid, req_opcode, req_a, req_b, alu_out, alu_z, rsp_ready,
    input  req_ready, alu_num1, alu_num2, alu_op,
           rsp_valid, rsp_result, rsp_zero, rsp_err, ops_done
  );
endinterface

// File: rtl/alu_sequencer.sv
// Single-transaction sequencer: decodes a LEGv8 opcode, presents registered
// operands to an external combinational ALU, waits one cycle for it to settle,
// captures the result and holds it until the consumer takes it.
// o_dbg_state encoding: 0 IDLE, 1 ISSUE, 2 CAPTURE, 3 RESP.
module alu_sequencer #(
  parameter int W = 64
) (
  input  logic       clk,
  input  logic       rst,
  alu_seq_if.slave   bus,
  output logic [1:0] o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t       r_state;
  state_t       w_next;
  logic         w_accept;
  logic         w_rsp_done;
  logic         w_op_valid;
  logic [3:0]   w_op_code;
  logic [W-1:0] r_num1;
  logic [W-1:0] r_num2;
  logic [3:0]   r_op;
  logic [W-1:0] r_result;
  logic         r_zero;
  logic         r_err;
  logic [15:0]  r_ops_done;

  // Handshake qualifiers; reset masks both ready and valid.
  assign bus.req_ready = (r_state == S_IDLE) & ~rst;
  assign bus.rsp_valid = (r_state == S_RESP) & ~rst;
  assign w_accept      = bus.req_valid & bus.req_ready;
  assign w_rsp_done    = bus.rsp_valid & bus.rsp_ready;

  // Opcode decode to ALU control; unknown opcodes map to 0000 and flag invalid.
  always_comb begin
    w_op_valid = 1'b1;
    w_op_code  = 4'b0000;
    casez (bus.req_opcode)
      11'b10001011000: w_op_code = 4'b0010; // ADD
      11'b11001011000: w_op_code = 4'b0110; // SUB
      11'b10001010000: w_op_code = 4'b0000; // AND
      11'b10101010000: w_op_code = 4'b0001; // ORR
      11'b11111000010: w_op_code = 4'b0010; // LDUR address add
      11'b11111000000: w_op_code = 4'b0010; // STUR address add
      11'b10110100???: w_op_code = 4'b0111; // CBZ pass-through
      default:         w_op_valid = 1'b0;
    endcase
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = w_op_valid ? S_ISSUE : S_RESP;
      S_ISSUE:   w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_RESP;
      S_RESP:    if (w_rsp_done) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // ALU operand/op registers: loaded on accept, held until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_num1 <= '0;
      r_num2 <= '0;
      r_op   <= 4'b0000;
    end else if (w_accept) begin
      r_num1 <= bus.req_a;
      r_num2 <= bus.req_b;
      r_op   <= w_op_code;
    end
  end

  // Response registers: error result on invalid accept, ALU result in CAPTURE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= '0;
      r_zero   <= 1'b0;
      r_err    <= 1'b0;
    end else if (w_accept && !w_op_valid) begin
      r_result <= '0;
      r_zero   <= 1'b0;
      r_err    <= 1'b1;
    end else if (r_state == S_CAPTURE) begin
      r_result <= bus.alu_out;
      r_zero   <= bus.alu_z;
      r_err    <= 1'b0;
    end
  end

  // Completed-response counter, wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst)             r_ops_done <= '0;
    else if (w_rsp_done) r_ops_done <= r_ops_done + 16'd1;
  end

  assign bus.alu_num1   = r_num1;
  assign bus.alu_num2   = r_num2;
  assign bus.alu_op     = r_op;
  assign bus.rsp_result = r_result;
  assign bus.rsp_zero   = r_zero;
  assign bus.rsp_err    = r_err;
  assign bus.ops_done   = r_ops_done;
  assign o_dbg_state    = r_state;

endmodule
